// File: rtl/match_controller.sv
// Round sequencer for the two-player game: idle, countdown, play, respawn and game-over flow.
// Index 0 of every per-player vector is P1, index 1 is P2.
module match_controller #(
  parameter int STOCKS         = 3,
  parameter int DIGIT_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 90,
  parameter int KO_X_MAX       = 640,
  parameter int KO_Y_MAX       = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_rate,
  input  logic       start,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [2:0] game_state,
  output logic       p1_enable,
  output logic       p2_enable,
  output logic       p1_respawn,
  output logic       p2_respawn,
  output logic [2:0] p1_stocks,
  output logic [2:0] p2_stocks,
  output logic [1:0] countdown_digit,
  output logic [1:0] winner
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_GAME_OVER = 3'd3;

  localparam int CW = (DIGIT_FRAMES > 1) ? $clog2(DIGIT_FRAMES) : 1;
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [CW-1:0] CNT_RELOAD = CW'(DIGIT_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [RW-1:0] TMR_RELOAD = RW'(RESPAWN_FRAMES);
  localparam logic [RW-1:0] TMR_ONE    = RW'(1'b1);
  localparam logic [2:0]    STOCK_INIT = 3'(STOCKS);
  localparam logic [10:0]   KO_X_L     = 11'(KO_X_MAX);
  localparam logic [10:0]   KO_Y_L     = 11'(KO_Y_MAX);

  logic [2:0]         state_q, state_d;
  logic               start_q;
  logic [1:0]         en_q, en_d;
  logic [1:0]         rsp_q, rsp_d;
  logic [1:0][2:0]    stk_q, stk_d;
  logic [1:0][RW-1:0] tmr_q, tmr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic [1:0]         winner_q, winner_d;
  logic               start_rise_s;
  logic [1:0]         out_s;

  assign start_rise_s = start & ~start_q;
  // Zero-extended compare so a left exit that wrapped to a large value also counts as a KO.
  assign out_s[0] = ({1'b0, p1_x} >= KO_X_L) || ({1'b0, p1_y} >= KO_Y_L);
  assign out_s[1] = ({1'b0, p2_x} >= KO_X_L) || ({1'b0, p2_y} >= KO_Y_L);

  // Next-state logic for the match flow, countdown, KO and respawn bookkeeping.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    rsp_d    = rsp_q;
    stk_d    = stk_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    winner_d = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) begin
          state_d  = ST_COUNTDOWN;
          stk_d    = {STOCK_INIT, STOCK_INIT};
          tmr_d    = '0;
          winner_d = 2'd0;
          digit_d  = 2'd3;
          cnt_d    = CNT_RELOAD;
          rsp_d    = 2'b11;
          en_d     = 2'b00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNTDOWN: begin
        if (frame_rate) begin
          // Requests raised at match start are seen for one frame, then dropped.
          rsp_d = 2'b00;
          if (cnt_q == '0) begin
            if (digit_q == 2'd1) begin
              state_d = ST_PLAY;
              digit_d = 2'd0;
              en_d    = 2'b11;
            end else begin
              digit_d = digit_q - 2'd1;
              cnt_d   = CNT_RELOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = ST_COUNTDOWN;
        end
      end
      ST_PLAY: begin
        if (frame_rate) begin
          for (int i = 0; i < 2; i++) begin
            if (en_q[i]) begin
              if (out_s[i]) begin
                en_d[i]  = 1'b0;
                stk_d[i] = stk_q[i] - 3'd1;
                tmr_d[i] = (stk_q[i] != 3'd1) ? TMR_RELOAD : '0;
              end else begin
                en_d[i] = 1'b1;
              end
            end else if (rsp_q[i]) begin
              rsp_d[i] = 1'b0;
              en_d[i]  = 1'b1;
            end else if ((stk_q[i] != 3'd0) && (tmr_q[i] != '0)) begin
              tmr_d[i] = tmr_q[i] - TMR_ONE;
              rsp_d[i] = (tmr_q[i] == TMR_ONE);
            end else begin
              tmr_d[i] = tmr_q[i];
            end
          end
          // Decided on post-KO stocks so a double KO on one tick is a draw.
          if ((stk_d[0] == 3'd0) || (stk_d[1] == 3'd0)) begin
            state_d  = ST_GAME_OVER;
            en_d     = 2'b00;
            winner_d = {stk_d[0] == 3'd0, stk_d[1] == 3'd0};
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_GAME_OVER: begin
        if (start_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAME_OVER;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        en_d     = 2'b00;
        rsp_d    = 2'b00;
        stk_d    = {STOCK_INIT, STOCK_INIT};
        tmr_d    = '0;
        cnt_d    = '0;
        digit_d  = 2'd0;
        winner_d = 2'd0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      en_q     <= 2'b00;
      rsp_q    <= 2'b00;
      stk_q    <= {STOCK_INIT, STOCK_INIT};
      tmr_q    <= '0;
      cnt_q    <= '0;
      digit_q  <= 2'd0;
      winner_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      en_q     <= en_d;
      rsp_q    <= rsp_d;
      stk_q    <= stk_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      winner_q <= winner_d;
    end
  end

  assign game_state      = state_q;
  assign p1_enable       = en_q[0];
  assign p2_enable       = en_q[1];
  assign p1_respawn      = rsp_q[0];
  assign p2_respawn      = rsp_q[1];
  assign p1_stocks       = stk_q[0];
  assign p2_stocks       = stk_q[1];
  assign countdown_digit = digit_q;
  assign winner          = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with short countdown and respawn timing.
module tb_match_controller;
  localparam int DF = 2;
  localparam int RF = 4;

  logic       clk = 1'b0;
  logic       reset, frame_rate, start;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [2:0] game_state, p1_stocks, p2_stocks;
  logic       p1_enable, p2_enable, p1_respawn, p2_respawn;
  logic [1:0] countdown_digit, winner;

  int errs   = 0;
  int checks = 0;

  match_controller #(
    .STOCKS(3), .DIGIT_FRAMES(DF), .RESPAWN_FRAMES(RF), .KO_X_MAX(640), .KO_Y_MAX(480)
  ) dut (
    .clk(clk), .reset(reset), .frame_rate(frame_rate), .start(start),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .game_state(game_state), .p1_enable(p1_enable), .p2_enable(p2_enable),
    .p1_respawn(p1_respawn), .p2_respawn(p2_respawn),
    .p1_stocks(p1_stocks), .p2_stocks(p2_stocks),
    .countdown_digit(countdown_digit), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame tick: frame_rate high across exactly one rising edge; returns at a falling edge.
  task automatic tick();
    @(negedge clk) frame_rate = 1'b1;
    @(negedge clk) frame_rate = 1'b0;
  endtask

  task automatic start_edge();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_countdown();
    int exp_d[6] = '{3, 2, 2, 1, 1, 0};
    chk("cd_state", int'(game_state), 1);
    chk("cd_digit_init", int'(countdown_digit), 3);
    chk("cd_respawn_init", int'({p1_respawn, p2_respawn}), 3);
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("cd_digit_t%0d", t + 1), int'(countdown_digit), exp_d[t]);
      if (t == 0) chk("cd_respawn_clear", int'({p1_respawn, p2_respawn}), 0);
    end
    chk("cd_play", int'(game_state), 2);
    chk("cd_enables", int'({p1_enable, p2_enable}), 3);
  endtask

  task automatic ko_recover(input logic k1, input logic k2);
    if (k1) p1_y = 10'd480;
    if (k2) p2_x = 10'd1023;
    tick();
    p1_y = 10'd100;
    p2_x = 10'd100;
    chk("kr_enables_low", int'({p1_enable, p2_enable}), int'({~k1, ~k2}));
    repeat (RF) tick();
    chk("kr_respawn", int'({p1_respawn, p2_respawn}), int'({k1, k2}));
    tick();
    chk("kr_enables_back", int'({p1_enable, p2_enable}), 3);
  endtask

  initial begin
    reset = 1'b1; frame_rate = 1'b0; start = 1'b0;
    p1_x = 10'd100; p1_y = 10'd100; p2_x = 10'd100; p2_y = 10'd100;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", int'(game_state), 0);
    chk("rst_enables", int'({p1_enable, p2_enable}), 0);
    chk("rst_respawn", int'({p1_respawn, p2_respawn}), 0);
    chk("rst_stocks", int'({p1_stocks, p2_stocks}), 8'o33);
    chk("rst_digit", int'(countdown_digit), 0);
    chk("rst_winner", int'(winner), 0);

    // Start held high across the whole countdown: only one transition.
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("cd_no_tick_digit", int'(countdown_digit), 3);
    run_countdown();
    start = 1'b0;

    // P1 leaves through the floor; respawn timing step by step.
    p1_y = 10'd480;
    tick();
    p1_y = 10'd100;
    chk("ko1_en", int'(p1_enable), 0);
    chk("ko1_stocks", int'(p1_stocks), 2);
    chk("ko1_p2_en", int'(p2_enable), 1);
    repeat (RF - 1) tick();
    chk("ko1_rsp_early", int'(p1_respawn), 0);
    tick();
    chk("ko1_rsp_rise", int'(p1_respawn), 1);
    @(negedge clk);
    chk("ko1_rsp_hold", int'(p1_respawn), 1);
    chk("ko1_en_still0", int'(p1_enable), 0);
    tick();
    chk("ko1_rsp_clear", int'(p1_respawn), 0);
    chk("ko1_en_back", int'(p1_enable), 1);

    // Just inside both limits: no KO.
    p1_x = 10'd639; p1_y = 10'd479;
    tick();
    chk("edge_in_en", int'(p1_enable), 1);
    chk("edge_in_stocks", int'(p1_stocks), 2);

    // Exactly at the x limit, then reset while the respawn timer runs.
    p1_x = 10'd640;
    tick();
    p1_x = 10'd100; p1_y = 10'd100;
    chk("ko2_stocks", int'(p1_stocks), 1);
    tick();
    tick();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", int'(game_state), 0);
    chk("mid_rst_stocks", int'({p1_stocks, p2_stocks}), 8'o33);
    chk("mid_rst_respawn", int'({p1_respawn, p2_respawn}), 0);
    chk("mid_rst_enables", int'({p1_enable, p2_enable}), 0);
    reset = 1'b0;

    // New match: P2 loses all stocks via a wrapped left exit.
    start_edge();
    run_countdown();
    ko_recover(1'b0, 1'b1);
    ko_recover(1'b0, 1'b1);
    chk("p2_one_stock", int'(p2_stocks), 1);
    p2_x = 10'd1023;
    tick();
    p2_x = 10'd100;
    chk("go1_p2_stocks", int'(p2_stocks), 0);
    chk("go1_state", int'(game_state), 3);
    chk("go1_winner", int'(winner), 1);
    chk("go1_enables", int'({p1_enable, p2_enable}), 0);
    chk("go1_p1_stocks", int'(p1_stocks), 3);
    tick();
    chk("go1_hold", int'(game_state), 3);

    start_edge();
    chk("go_to_idle", int'(game_state), 0);
    chk("idle_winner_kept", int'(winner), 1);
    start_edge();
    chk("restart_state", int'(game_state), 1);
    chk("restart_stocks", int'({p1_stocks, p2_stocks}), 8'o33);
    chk("restart_winner", int'(winner), 0);
    run_countdown();

    // Both players KO'd together until one stock each, then a draw.
    ko_recover(1'b1, 1'b1);
    ko_recover(1'b1, 1'b1);
    chk("both_one_stock", int'({p1_stocks, p2_stocks}), 8'o11);
    p1_y = 10'd600; p2_x = 10'd700;
    tick();
    chk("draw_state", int'(game_state), 3);
    chk("draw_winner", int'(winner), 3);
    chk("draw_stocks", int'({p1_stocks, p2_stocks}), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
